// File: rtl/comm_rx_pkg.sv
// Shared types and constants for the symbol receive path.
package comm_rx_pkg;

  localparam int SYM_W         = 2;
  localparam int BYTE_W        = 8;
  localparam int SYMS_PER_BYTE = BYTE_W / SYM_W;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hEB90;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } rx_state_t;

  function automatic int mismatch_bits(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (a[i] != b[i]) n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sym_packer.sv
// Packs four 2-bit symbols (MSB first) into a byte; byte_rdy marks the 4th symbol.
module sym_packer
  import comm_rx_pkg::*;
(
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              sym_en,
  input  logic [SYM_W-1:0]  sym_in,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_rdy
);

  logic [1:0]              sym_cnt;
  logic [BYTE_W-SYM_W-1:0] acc;

  always_ff @(posedge sys_clk) begin
    if (!reset || clear) begin
      sym_cnt <= '0;
      acc     <= '0;
    end else if (sym_en) begin
      sym_cnt <= sym_cnt + 2'd1;
      acc     <= {acc[BYTE_W-2*SYM_W-1:0], sym_in};
    end
  end

  // acc always holds the three most recent symbols, so the byte completes combinationally
  assign byte_data = {acc, sym_in};
  assign byte_rdy  = sym_en && (sym_cnt == 2'd3);

endmodule

// File: rtl/symbol_deframer.sv
// Frame deframer: sliding sync hunt, length byte, payload bytes, XOR checksum.
//   state      | meaning
//   ST_HUNT    | shifting symbols, looking for the sync word
//   ST_LEN     | collecting the length byte N
//   ST_PAYLOAD | collecting N payload bytes, emitting each one
//   ST_CHECK   | collecting checksum byte, then pulse done/err
module symbol_deframer
  import comm_rx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int          SYNC_TOL  = 0
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [SYM_W-1:0]  sym_in,
  input  logic              sym_valid,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              frame_done,
  output logic              frame_err,
  output logic              in_frame,
  output logic [7:0]        frame_cnt,
  output logic [7:0]        err_cnt
);

  rx_state_t   state, state_nxt;
  logic [15:0] shift_reg, shift_nxt, shifted;
  logic [7:0]  len_q, len_nxt;
  logic [7:0]  byte_cnt, cnt_nxt;
  logic [7:0]  xor_q, xor_nxt;
  logic [7:0]  byte_out_nxt, fcnt_nxt, ecnt_nxt;
  logic        byte_valid_nxt, done_nxt, err_nxt;

  logic [BYTE_W-1:0] byte_data;
  logic              byte_rdy;

  sym_packer u_packer (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .clear     (state == ST_HUNT),
    .sym_en    (sym_valid && (state != ST_HUNT)),
    .sym_in    (sym_in),
    .byte_data (byte_data),
    .byte_rdy  (byte_rdy)
  );

  assign shifted  = {shift_reg[13:0], sym_in};
  assign in_frame = (state != ST_HUNT);

  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift_reg;
    len_nxt        = len_q;
    cnt_nxt        = byte_cnt;
    xor_nxt        = xor_q;
    byte_out_nxt   = byte_out;
    byte_valid_nxt = 1'b0;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    fcnt_nxt       = frame_cnt;
    ecnt_nxt       = err_cnt;

    case (state)
      ST_HUNT: begin
        if (sym_valid) begin
          if (mismatch_bits(shifted, SYNC_WORD) <= SYNC_TOL) begin
            state_nxt = ST_LEN;
            shift_nxt = '0;
            cnt_nxt   = '0;
            xor_nxt   = '0;
          end else begin
            shift_nxt = shifted;
          end
        end
      end
      ST_LEN: begin
        if (byte_rdy) begin
          len_nxt = byte_data;
          if (byte_data == 8'd0) begin
            err_nxt   = 1'b1;
            ecnt_nxt  = sat_inc(err_cnt);
            state_nxt = ST_HUNT;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_rdy) begin
          byte_out_nxt   = byte_data;
          byte_valid_nxt = 1'b1;
          xor_nxt        = xor_q ^ byte_data;
          cnt_nxt        = byte_cnt + 8'd1;
          if (byte_cnt + 8'd1 == len_q) state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (byte_rdy) begin
          if (byte_data == xor_q) begin
            done_nxt = 1'b1;
            fcnt_nxt = sat_inc(frame_cnt);
          end else begin
            err_nxt  = 1'b1;
            ecnt_nxt = sat_inc(err_cnt);
          end
          state_nxt = ST_HUNT;
          xor_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state      <= ST_HUNT;
      shift_reg  <= '0;
      len_q      <= '0;
      byte_cnt   <= '0;
      xor_q      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      len_q      <= len_nxt;
      byte_cnt   <= cnt_nxt;
      xor_q      <= xor_nxt;
      byte_out   <= byte_out_nxt;
      byte_valid <= byte_valid_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
      frame_cnt  <= fcnt_nxt;
      err_cnt    <= ecnt_nxt;
    end
  end

endmodule

// File: tb/tb_symbol_deframer.sv
// Scoreboard bench: two deframers (tolerance 0 and 1) share one randomized symbol stream.
module tb_symbol_deframer;

  logic       sys_clk   = 1'b0;
  logic       reset     = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_in    = 2'd0;

  logic [7:0] bo0, bo1, fc0, fc1, ec0, ec1;
  logic       bv0, bv1, fd0, fd1, fe0, fe1, if0, if1;

  symbol_deframer #(.SYNC_WORD(16'hEB90), .SYNC_TOL(0)) dut0 (
    .sys_clk(sys_clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .byte_out(bo0), .byte_valid(bv0), .frame_done(fd0), .frame_err(fe0),
    .in_frame(if0), .frame_cnt(fc0), .err_cnt(ec0));

  symbol_deframer #(.SYNC_WORD(16'hEB90), .SYNC_TOL(1)) dut1 (
    .sys_clk(sys_clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .byte_out(bo1), .byte_valid(bv1), .frame_done(fd1), .frame_err(fe1),
    .in_frame(if1), .frame_cnt(fc1), .err_cnt(ec1));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // event codes: 1 = byte, 2 = frame_done, 4 = frame_err
  typedef struct {
    int         kind;
    logic [7:0] val;
    int         cyc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  localparam logic [15:0] SYNC = 16'hEB90;

  int          errors = 0;
  int          checks = 0;
  int          tol   [2];
  int          m_pos [2];
  logic [15:0] m_win [2];
  logic [7:0]  m_cur [2];
  logic [7:0]  m_len [2];
  logic [7:0]  m_xor [2];
  int          m_fcnt[2];
  int          m_ecnt[2];
  logic [7:0]  tx_pl[$];

  task automatic check(input int d, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, want %0h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int d, input int k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = cyc + 1;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Reference: position of each symbol since sync decides which byte of the frame it belongs to.
  function automatic void model_step(input int d, input logic [1:0] s);
    logic [15:0] w;
    int          b;
    if (m_pos[d] < 0) begin
      w        = {m_win[d][13:0], s};
      m_win[d] = w;
      if ($countones(w ^ SYNC) <= tol[d]) begin
        m_pos[d] = 0;
        m_win[d] = 16'h0;
        m_xor[d] = 8'h0;
        m_cur[d] = 8'h0;
      end
    end else begin
      m_cur[d] = {m_cur[d][5:0], s};
      m_pos[d]++;
      if (m_pos[d] % 4 == 0) begin
        b = m_pos[d] / 4 - 1;
        if (b == 0) begin
          m_len[d] = m_cur[d];
          if (m_cur[d] == 8'h0) begin
            push_ev(d, 4, 8'h0);
            if (m_ecnt[d] < 255) m_ecnt[d]++;
            m_pos[d] = -1;
          end
        end else if (b <= int'(m_len[d])) begin
          push_ev(d, 1, m_cur[d]);
          m_xor[d] = m_xor[d] ^ m_cur[d];
        end else begin
          if (m_cur[d] == m_xor[d]) begin
            push_ev(d, 2, 8'h0);
            if (m_fcnt[d] < 255) m_fcnt[d]++;
          end else begin
            push_ev(d, 4, 8'h0);
            if (m_ecnt[d] < 255) m_ecnt[d]++;
          end
          m_pos[d] = -1;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pos[d]  = -1;
      m_win[d]  = 16'h0;
      m_cur[d]  = 8'h0;
      m_len[d]  = 8'h0;
      m_xor[d]  = 8'h0;
      m_fcnt[d] = 0;
      m_ecnt[d] = 0;
    end
    q0.delete();
    q1.delete();
  endfunction

  task automatic mon(input int d, input logic bv, input logic [7:0] bo, input logic fd,
                     input logic fe, input logic inf, input logic [7:0] fc, input logic [7:0] ec);
    ev_t e;
    int  code;
    int  n;
    if (!reset) begin
      check(d, "reset_outputs", {bv, fd, fe, inf, bo, fc, ec}, 0);
    end else begin
      n = (d == 0) ? q0.size() : q1.size();
      if (n > 0) begin
        e = (d == 0) ? q0[0] : q1[0];
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL missing_event dut%0d: got none, want kind %0d val %0h at cycle %0d", d, e.kind, e.val, e.cyc);
          if (d == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
          n--;
        end
      end
      if (bv || fd || fe) begin
        code = (bv ? 1 : 0) + (fd ? 2 : 0) + (fe ? 4 : 0);
        if (n == 0) begin
          check(d, "unexpected_event", code, 0);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check(d, "event", code * 256 + (bv ? int'(bo) : 0), e.kind * 256 + int'(e.val));
          check(d, "event_cycle", cyc, e.cyc);
        end
      end
      check(d, "in_frame", int'(inf), (m_pos[d] >= 0) ? 1 : 0);
      check(d, "frame_cnt", int'(fc), m_fcnt[d]);
      check(d, "err_cnt", int'(ec), m_ecnt[d]);
    end
  endtask

  always @(posedge sys_clk) begin
    #1;
    mon(0, bv0, bo0, fd0, fe0, if0, fc0, ec0);
    mon(1, bv1, bo1, fd1, fe1, if1, fc1, ec1);
  end

  task automatic drive(input logic v, input logic [1:0] s);
    @(negedge sys_clk);
    sym_valid = v;
    sym_in    = s;
    if (v) begin
      model_step(0, s);
      model_step(1, s);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'd0);
  endtask

  task automatic send_sym(input logic [1:0] s, input int gap);
    idle(gap);
    drive(1'b1, s);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < 4; i++) send_sym(b[7-2*i -: 2], gap);
  endtask

  task automatic send_frame(input logic [15:0] sw, input logic [7:0] len,
                            input logic [7:0] flip, input int gap);
    logic [7:0] x;
    x = 8'h0;
    send_byte(sw[15:8], gap);
    send_byte(sw[7:0], gap);
    send_byte(len, gap);
    if (len != 8'h0) begin
      for (int i = 0; i < int'(len); i++) begin
        send_byte(tx_pl[i], gap);
        x = x ^ tx_pl[i];
      end
      send_byte(x ^ flip, gap);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge sys_clk);
    reset     = 1'b0;
    sym_valid = 1'b0;
    model_reset();
    repeat (n) @(negedge sys_clk);
    reset = 1'b1;
  endtask

  initial begin
    tol[0] = 0;
    tol[1] = 1;
    model_reset();
    repeat (3) @(negedge sys_clk);
    reset = 1'b1;

    // good frame, bad checksum, zero length
    tx_pl = '{8'hA5, 8'h3C};
    send_frame(SYNC, 8'd2, 8'h00, 0);  idle(4);
    send_frame(SYNC, 8'd2, 8'h01, 0);  idle(4);
    send_frame(SYNC, 8'd0, 8'h00, 0);  idle(4);
    // gapped symbols
    send_frame(SYNC, 8'd2, 8'h00, 3);  idle(4);
    // one-bit sync error: only the tolerant instance locks
    send_frame(16'hEB91, 8'd2, 8'h00, 0); idle(4);
    // sliding match after a partial sync
    send_byte(8'hEB, 0);
    send_frame(SYNC, 8'd2, 8'h00, 0);  idle(4);

    // reset after the first payload byte, then a clean frame
    tx_pl = '{8'h11, 8'h22, 8'h33};
    send_byte(SYNC[15:8], 0);
    send_byte(SYNC[7:0], 0);
    send_byte(8'd3, 0);
    send_byte(8'h11, 0);
    idle(3);
    do_reset(2);
    tx_pl = '{8'hA5, 8'h3C};
    send_frame(SYNC, 8'd2, 8'h00, 0);  idle(4);

    // randomized frames with noise, gaps, sync bit errors and bad checksums
    for (int f = 0; f < 40; f++) begin
      logic [15:0] sw;
      logic [7:0]  fl;
      int          len;
      repeat ($urandom_range(0, 6)) send_sym(2'($urandom_range(0, 3)), 0);
      sw = SYNC;
      if ($urandom_range(0, 3) == 0) sw[$urandom_range(0, 15)] ^= 1'b1;
      len = $urandom_range(0, 5);
      tx_pl.delete();
      for (int i = 0; i < len; i++) tx_pl.push_back(8'($urandom_range(0, 255)));
      fl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(sw, 8'(len), fl, $urandom_range(0, 2));
      idle($urandom_range(0, 3));
    end
    idle(8);

    // counter saturation
    do_reset(1);
    for (int f = 0; f < 260; f++) send_frame(SYNC, 8'd0, 8'h00, 0);
    tx_pl = '{8'h5A};
    for (int f = 0; f < 260; f++) send_frame(SYNC, 8'd1, 8'h00, 0);
    idle(8);

    check(0, "queue_drained", q0.size(), 0);
    check(1, "queue_drained", q1.size(), 0);
    check(0, "frame_cnt_saturated", int'(fc0), 255);
    check(0, "err_cnt_saturated", int'(ec0), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
